muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage of the pipelined CPU. It owns the HI/LO architectural registers and runs a MUL_LATENCY-cycle multiply and a 32-iteration restoring divide. It asserts a pipeline stall whenever a dependent HI/LO operation arrives while the unit is busy. It also handles MTHI/MTLO writes and flush-cancel.

---
 rtl/muldiv_ctrl.sv | 167 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: fixed-latency multiply, restoring divide,
// MTHI/MTLO and flush-cancel. Define MULDIV_DIV0_TRAP_EN to add the div0 trap pulse output.
module muldiv_ctrl #(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_ITERS   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        rd_hilo,
  input  logic        cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
`ifdef MULDIV_DIV0_TRAP_EN
  output logic        div0,
`endif
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]  state_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] opa_q;   // multiplicand, or dividend shifting out / quotient shifting in
  logic [31:0] opb_q;   // multiplier or divisor
  logic [31:0] rem_q;
  logic        msgn_q, qneg_q, rneg_q, dz_q, done_q;
`ifdef MULDIV_DIV0_TRAP_EN
  logic        div0_q;
`endif

  logic        op_act, accept, is_sdiv;
  logic [31:0] x_abs, y_abs, q_fix, r_fix;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] shifted, diff;
  logic        ge;

  always_comb begin
    op_act  = op_valid && (op != 3'd0) && (op != 3'd7);
    accept  = (state_q == IDLE) && op_valid && !cancel;
    is_sdiv = (op == 3'd3);
    x_abs   = x[31] ? (32'd0 - x) : x;
    y_abs   = y[31] ? (32'd0 - y) : y;
    // Sign-extend to 64 bits; the truncated 64-bit product is then correct for both signednesses.
    mul_a   = {{32{msgn_q & opa_q[31]}}, opa_q};
    mul_b   = {{32{msgn_q & opb_q[31]}}, opb_q};
    prod    = mul_a * mul_b;
    shifted = {rem_q, opa_q[31]};
    diff    = shifted - {1'b0, opb_q};
    ge      = !diff[32];
    q_fix   = qneg_q ? (32'd0 - opa_q) : opa_q;
    r_fix   = rneg_q ? (32'd0 - rem_q) : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      rem_q   <= 32'd0;
      msgn_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      div0_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      div0_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (op)
              3'd1, 3'd2: begin
                opa_q   <= x;
                opb_q   <= y;
                msgn_q  <= (op == 3'd1);
                cnt_q   <= 5'(MUL_LATENCY - 1);
                state_q <= MUL;
              end
              3'd3, 3'd4: begin
                opa_q   <= is_sdiv ? x_abs : x;
                opb_q   <= is_sdiv ? y_abs : y;
                // A zero divisor parks the dividend in rem so the sign fix restores x.
                rem_q   <= (y == 32'd0) ? (is_sdiv ? x_abs : x) : 32'd0;
                qneg_q  <= is_sdiv & (x[31] ^ y[31]);
                rneg_q  <= is_sdiv & x[31];
                dz_q    <= (y == 32'd0);
                cnt_q   <= 5'(DIV_ITERS - 1);
                state_q <= (y == 32'd0) ? FIX : DIV;
              end
              3'd5:    hi_q <= x;
              3'd6:    lo_q <= x;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cancel) begin
            state_q <= IDLE;
          end else if (cnt_q == 5'd0) begin
            {hi_q, lo_q} <= prod;
            state_q      <= IDLE;
            done_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        DIV: begin
          if (cancel) begin
            state_q <= IDLE;
          end else begin
            rem_q <= ge ? diff[31:0] : shifted[31:0];
            opa_q <= {opa_q[30:0], ge};
            if (cnt_q == 5'd0) state_q <= FIX;
            else               cnt_q   <= cnt_q - 5'd1;
          end
        end
        default: begin
          if (cancel) begin
            state_q <= IDLE;
          end else begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            if (dz_q) begin
`ifdef MULDIV_DIV0_TRAP_EN
              div0_q <= 1'b1;
`else
              hi_q <= r_fix;
              lo_q <= 32'hFFFF_FFFF;
`endif
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
          end
        end
      endcase
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy && (op_act || rd_hilo);
  assign done  = done_q;
`ifdef MULDIV_DIV0_TRAP_EN
  assign div0  = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: an arithmetic reference model with per-cycle comparison,
// plus literal hi/lo/done pins at the points of interest.
module tb_muldiv_ctrl;

  localparam int MulLat = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] x = 32'd0;
  logic [31:0] y = 32'd0;
  logic        rd_hilo = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall, done;
`ifdef MULDIV_DIV0_TRAP_EN
  logic        div0;
`endif

  muldiv_ctrl #(.MUL_LATENCY(MulLat), .DIV_ITERS(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .x        (x),
    .y        (y),
    .rd_hilo  (rd_hilo),
    .cancel   (cancel),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall),
`ifdef MULDIV_DIV0_TRAP_EN
    .div0     (div0),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference model state: architectural hi/lo, cycles of busy left, pending result.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] m_res = 64'd0;
  logic        m_done = 1'b0;
  int          m_left = 0;
`ifdef MULDIV_DIV0_TRAP_EN
  logic        m_pdz = 1'b0;
  logic        m_div0 = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic        pin_en = 1'b0;
  logic [31:0] pin_hi = 32'd0, pin_lo = 32'd0;
  logic        pin_done = 1'b0;

  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    int     q, r;
    case (o)
      3'd1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] b);
    if (o == 3'd1 || o == 3'd2) return MulLat;
    return (b == 32'd0) ? 1 : 33;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_done = 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      m_div0 = 1'b0;
`endif
    end else begin
      m_done = 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      m_div0 = 1'b0;
`endif
      if (m_left != 0) begin
        if (cancel) begin
          m_left = 0;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_done = 1'b1;
`ifdef MULDIV_DIV0_TRAP_EN
            if (m_pdz) m_div0 = 1'b1;
            else {m_hi, m_lo} = m_res;
`else
            {m_hi, m_lo} = m_res;
`endif
          end
        end
      end else if (op_valid && !cancel) begin
        case (op)
          3'd5: m_hi = x;
          3'd6: m_lo = x;
          3'd1, 3'd2, 3'd3, 3'd4: begin
            m_res  = model_res(op, x, y);
            m_left = model_lat(op, y);
`ifdef MULDIV_DIV0_TRAP_EN
            m_pdz  = (op == 3'd3 || op == 3'd4) && (y == 32'd0);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    logic exp_stall;
    @(negedge clk);
    exp_stall = (m_left != 0) && ((op_valid && op != 3'd0 && op != 3'd7) || rd_hilo);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("stall", 32'(stall), 32'(exp_stall));
`ifdef MULDIV_DIV0_TRAP_EN
    chk("div0", 32'(div0), 32'(m_div0));
`endif
    if (pin_en) begin
      chk("pin_hi", hi, pin_hi);
      chk("pin_lo", lo, pin_lo);
      chk("pin_done", 32'(done), 32'(pin_done));
      chk("model_hi", m_hi, pin_hi);
      chk("model_lo", m_lo, pin_lo);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; x = a; y = b;
    cyc();
    op_valid = 1'b0; op = 3'd0;
  endtask

  task automatic pin(input logic [31:0] h, input logic [31:0] l, input logic d);
    pin_hi = h; pin_lo = l; pin_done = d; pin_en = 1'b1;
    @(negedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    pin(32'd0, 32'd0, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    pin(32'd0, 32'd0, 1'b0);

    issue(3'd1, 32'hFFFF_FFFD, 32'd5);
    repeat (MulLat) cyc();
    pin(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
    issue(3'd2, 32'hFFFF_FFFD, 32'd5);
    repeat (MulLat) cyc();
    pin(32'd4, 32'hFFFF_FFF1, 1'b1);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    repeat (33) cyc();
    pin(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);

    issue(3'd4, 32'd7, 32'd0);
    cyc();
`ifdef MULDIV_DIV0_TRAP_EN
    pin(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
`else
    pin(32'd7, 32'hFFFF_FFFF, 1'b1);
`endif

    // MFHI and a dependent MULT arrive mid-divide; both stall, MULT is taken in the done cycle.
    issue(3'd4, 32'd100, 32'd7);
    repeat (4) cyc();
    rd_hilo = 1'b1;
    op_valid = 1'b1; op = 3'd1; x = 32'd3; y = 32'd4;
    repeat (29) cyc();
    pin(32'd2, 32'd14, 1'b1);
    cyc();
    op_valid = 1'b0; op = 3'd0; rd_hilo = 1'b0;
    repeat (MulLat) cyc();
    pin(32'd0, 32'd12, 1'b1);

    op_valid = 1'b1; op = 3'd5; x = 32'h1234_5678;
    cyc();
    pin(32'h1234_5678, 32'd12, 1'b0);
    op = 3'd6; x = 32'hCAFE_BABE;
    cyc();
    op_valid = 1'b0; op = 3'd0;
    pin(32'h1234_5678, 32'hCAFE_BABE, 1'b0);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (33) cyc();
    pin(32'd0, 32'h8000_0000, 1'b1);

    issue(3'd3, 32'd1000, 32'd3);
    repeat (9) cyc();
    cancel = 1'b1;
    cyc();
    op_valid = 1'b1; op = 3'd5; x = 32'hDEAD_BEEF;
    cyc();
    op_valid = 1'b0; op = 3'd0; cancel = 1'b0;
    pin(32'd0, 32'h8000_0000, 1'b0);
    op_valid = 1'b1; op = 3'd7; x = 32'd1; y = 32'd1;
    cyc();
    op_valid = 1'b0; op = 3'd0;
    pin(32'd0, 32'h8000_0000, 1'b0);

    issue(3'd1, 32'd7, 32'd9);
    cyc();
    rst_n = 1'b0;
    pin(32'd0, 32'd0, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (MulLat) cyc();
    pin(32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
